tri_word_serializer: RTL and testbench
======================================

// Module: tri_word_serializer
// PURPOSE
// - Transmit side of the 6-word triangle buffer link: captures one Triangle3D plus Color8 and streams it as six 32-bit words.
// - Uses a valid/ready handshake; feeds the word buffer that is unpacked downstream into texel_vertices/texel_color.
// - Sits between the bisect/setup stage and the AHB-side word buffer.
// PARAMETERS
// - WORD_W    32  output word width; only 32 is supported.
// - COORD_W   16  width of each vertex coordinate field.
// - NUM_WORDS 6   words per triangle; the word index counter is $clog2(NUM_WORDS) bits.
// PORTS
// - clk         in   1     single clock; all logic on posedge.
// - n_rst       in   1     reset: synchronous, active-high (1 = reset).
// - tri_in      in   Tri3D triangle: p, q, r, each with x/y/z of COORD_W bits.
// - color_in    in   Color8 colour: r/g/b, 8 bits each.
// - in_valid    in   1     tri_in and color_in are valid.
// - in_ready    out  1     block can capture a triangle this cycle.
// - word_out    out  32    current packed word.
// - word_valid  out  1     word_out is valid.
// - word_ready  in   1     consumer accepts word_out.
// - word_idx    out  3     index of word_out, 0..5.
// - word_last   out  1     high when word_idx == 5 and word_valid is high.
// - tri_count   out  16    triangles fully sent; wraps modulo 2^16.
// BEHAVIOUR
// - Reset (n_rst = 1 at a posedge):
//   - state = IDLE; word_valid = 0; word_idx = 0; tri_count = 0.
//   - word_out = 0; holding register cleared.
//   - Reset overrides everything, including mid-triangle: the partial triangle is dropped and nothing is re-sent.
// - Word packing, [hi:lo]:
//   - W0 = {p.y, p.x}
//   - W1 = {q.x, p.z}
//   - W2 = {q.z, q.y}
//   - W3 = {r.y, r.x}
//   - W4 = {color.g, color.r, r.z}
//   - W5 = {24'h0, color.b}
// - Capture:
//   - A transfer happens when in_valid && in_ready at a posedge; both inputs latch into the holding register.
//   - in_ready = (state == IDLE) || (word_valid && word_ready && word_last).
//   - This gives zero-bubble back-to-back triangles.
// - Latency: a triangle captured at edge N presents W0 with word_valid = 1 after edge N (cycle N+1).
// - FSM:
//   - IDLE -> SEND on capture.
//   - SEND advances word_idx on each word_valid && word_ready.
//   - At idx 5 with ready:
//     - capture in the same cycle -> stay in SEND, idx = 0, new triangle.
//     - otherwise -> IDLE and word_valid = 0.
// - Stall rule: while word_valid && !word_ready, word_out, word_idx and word_last hold stable. word_valid never drops without a handshake.
// - word_out is registered: selected from the holding register by the next index. No combinational path from word_ready to word_out.
// - tri_count increments by 1 on the W5 handshake. It wraps from 16'hFFFF to 0.
// - in_valid high while in_ready is low: no capture. The producer must hold its data.
// - Unused coordinate bits pass through unmodified; no sign handling.
// STRUCTURE
// - Shared package gpu_pkg:
//   - Vertex3D, Triangle3D, Color8 typedefs.
//   - TRI_WORDS = 6 and COORD_W constants.
//   - function pack_tri_word(tri, col, idx), also used by the bench model.
// - Sub-module: none required.
//   - The packing mux is the gpu_pkg function.
//   - FSM, counter and holding register live in this module.
// TESTING
// - Single triangle, word_ready held 1:
//   - Stimulus: p = (1,2,3), q = (4,5,6), r = (7,8,9), color = (AA,BB,CC).
//   - Expect: 00020001, 00040003, 00060005, 00080007, BBAA0009, 000000CC on six consecutive cycles.
//   - Expect: word_last only on the 6th word; tri_count = 1.
// - Back-to-back:
//   - Stimulus: in_valid held with two triangles, word_ready = 1.
//   - Expect: 12 words with no gap cycle; in_ready pulses in the W5 cycle; tri_count = 2.
// - Backpressure:
//   - Stimulus: word_ready = 0 for 3 cycles at W2.
//   - Expect: word_out = W2 and word_idx = 2, stable throughout; sequence resumes with W3.
// - Reset mid-triangle:
//   - Stimulus: n_rst = 1 for one edge after W3 is accepted.
//   - Expect: next cycle word_valid = 0, tri_count = 0, in_ready = 1.
//   - Expect: next triangle starts at W0.
// - Counter wrap:
//   - Stimulus: preload tri_count = FFFF via force, send one triangle.
//   - Expect: tri_count = 0000.
// - Random valid/ready throttling over 1000 triangles:
//   - Expect: scoreboard via pack_tri_word matches; no dropped or duplicated words.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU types and helpers for the triangle word link.
// Contents:
//   Vertex3D / Triangle3D / Color8   packed geometry and colour types
//   WORD_W, COORD_W, TRI_WORDS       link constants (only 32-bit words supported)
//   ser_state_e                      serializer FSM states
//   pack_tri_word(t, col, idx)       word packing mux, shared with the bench model
package gpu_pkg;

    localparam int WORD_W    = 32;
    localparam int COORD_W   = 16;
    localparam int TRI_WORDS = 6;
    localparam int IDX_W     = $clog2(TRI_WORDS);
    localparam int TCNT_W    = 16;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRI_WORDS - 1);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } Vertex3D;

    typedef struct packed {
        Vertex3D p;
        Vertex3D q;
        Vertex3D r;
    } Triangle3D;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } Color8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    // Word layout of the six-word triangle record, [hi:lo].
    function automatic logic [WORD_W-1:0] pack_tri_word(
        input Triangle3D        t,
        input Color8            col,
        input logic [IDX_W-1:0] idx
    );
        logic [WORD_W-1:0] w;
        w = '0;
        case (idx)
            3'd0:    w = {t.p.y, t.p.x};
            3'd1:    w = {t.q.x, t.p.z};
            3'd2:    w = {t.q.z, t.q.y};
            3'd3:    w = {t.r.y, t.r.x};
            3'd4:    w = {col.g, col.r, t.r.z};
            3'd5:    w = {24'h0, col.b};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/tri_word_serializer.sv
// Transmit side of the six-word triangle link. Captures one triangle plus
// colour on an in_valid/in_ready handshake and streams it as six 32-bit
// words on a word_valid/word_ready handshake.
// Ports:
//   clk         clock, all logic on posedge
//   n_rst       synchronous reset, active high (name kept from the link bus)
//   tri_in      triangle p/q/r vertices
//   color_in    r/g/b colour
//   in_valid    tri_in/color_in valid
//   in_ready    block can capture this cycle
//   word_out    registered packed word
//   word_valid  word_out valid
//   word_ready  consumer accepts word_out
//   word_idx    index of word_out, 0..5
//   word_last   word_idx == 5 while word_valid
//   tri_count   triangles fully sent, wraps at 2^16
module tri_word_serializer
    import gpu_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  Triangle3D         tri_in,
    input  Color8             color_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [IDX_W-1:0]  word_idx,
    output logic              word_last,
    output logic [TCNT_W-1:0] tri_count
);

    ser_state_e        state, state_nxt;
    Triangle3D         hold_tri;
    Color8             hold_col;
    logic [IDX_W-1:0]  idx_nxt;
    logic [WORD_W-1:0] word_nxt;
    logic              fire;
    logic              capture;

    // Output is valid exactly while a triangle is being sent.
    assign word_valid = (state == SEND);
    assign word_last  = word_valid && (word_idx == LAST_IDX);
    assign fire       = word_valid && word_ready;
    // Accepting a new triangle on the final-word handshake keeps the
    // stream gap-free between triangles.
    assign in_ready   = (state == IDLE) || (fire && word_last);
    assign capture    = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        idx_nxt   = word_idx;
        word_nxt  = word_out;
        if (capture) begin
            // Holding register is loaded on this same edge, so W0 is
            // packed straight from the inputs.
            state_nxt = SEND;
            idx_nxt   = '0;
            word_nxt  = pack_tri_word(tri_in, color_in, '0);
        end else if (fire) begin
            if (word_last) begin
                state_nxt = IDLE;
                idx_nxt   = '0;
                word_nxt  = '0;
            end else begin
                idx_nxt  = word_idx + 1'b1;
                word_nxt = pack_tri_word(hold_tri, hold_col, word_idx + 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state     <= IDLE;
            word_idx  <= '0;
            word_out  <= '0;
            hold_tri  <= '0;
            hold_col  <= '0;
            tri_count <= '0;
        end else begin
            state    <= state_nxt;
            word_idx <= idx_nxt;
            word_out <= word_nxt;
            if (capture) begin
                hold_tri <= tri_in;
                hold_col <= color_in;
            end
            if (fire && word_last)
                tri_count <= tri_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_tri_word_serializer.sv
module tb_tri_word_serializer;
    import gpu_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    Triangle3D   tri_in;
    Color8       color_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [2:0]  word_idx;
    logic        word_last;
    logic [15:0] tri_count;

    tri_word_serializer dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tri_in     (tri_in),
        .color_in   (color_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_idx   (word_idx),
        .word_last  (word_last),
        .tri_count  (tri_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic [2:0]  idx;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          hs_cnt   = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_w     = '0;
    logic [2:0]  prev_idx   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, req, $time);
        end
    endtask

    // Runs at every negedge: scoreboard pop/compare and stall stability.
    task automatic mon_step();
        exp_t e;
        if (n_rst !== 1'b0) begin
            stall_prev = 1'b0;
            return;
        end
        if (stall_prev) begin
            chk("stall_valid", 32'(word_valid), 32'd1);
            chk("stall_word",  word_out,        prev_w);
            chk("stall_idx",   32'(word_idx),   32'(prev_idx));
        end
        if (word_valid === 1'b1 && word_ready === 1'b1) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_word actual=%08h idx=%0d required=none", word_out, word_idx);
            end else begin
                e = exp_q.pop_front();
                chk("word",      word_out,        e.w);
                chk("word_idx",  32'(word_idx),   32'(e.idx));
                chk("word_last", 32'(word_last),  32'(e.idx == 3'd5));
            end
            if (word_last === 1'b1)
                chk("in_ready_w5", 32'(in_ready), 32'd1);
        end
        stall_prev = (word_valid === 1'b1) && (word_ready === 1'b0);
        prev_w     = word_out;
        prev_idx   = word_idx;
    endtask

    function automatic Triangle3D mk_tri(input int px, py, pz, qx, qy, qz, rx, ry, rz);
        Triangle3D t;
        t.p.x = 16'(px); t.p.y = 16'(py); t.p.z = 16'(pz);
        t.q.x = 16'(qx); t.q.y = 16'(qy); t.q.z = 16'(qz);
        t.r.x = 16'(rx); t.r.y = 16'(ry); t.r.z = 16'(rz);
        return t;
    endfunction

    function automatic Color8 mk_col(input int r, g, b);
        Color8 c;
        c.r = 8'(r); c.g = 8'(g); c.b = 8'(b);
        return c;
    endfunction

    task automatic push_exp(input logic [31:0] w, input int idx);
        exp_t e;
        e.w   = w;
        e.idx = 3'(idx);
        exp_q.push_back(e);
    endtask

    // Presents a triangle and returns #1 after the capture edge; in_valid
    // is left high so the caller decides whether to follow up back-to-back.
    task automatic send_tri(input Triangle3D t, input Color8 c, input bit use_model);
        tri_in   = t;
        color_in = c;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                if (use_model)
                    for (int k = 0; k < 6; k++)
                        push_exp(pack_tri_word(t, c, 3'(k)), k);
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL capture_timeout actual=no_in_ready required=in_ready");
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst      = 1'b1;
        in_valid   = 1'b0;
        word_ready = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Triangle3D ta, tb2, tc;
        Color8     ca, cb, cc;
        bit        rnd_done;
        int        base;
        int        got;

        n_rst      = 1'b1;
        in_valid   = 1'b0;
        word_ready = 1'b0;
        tri_in     = '0;
        color_in   = '0;

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b0;

        // Reset state
        chk("rst_valid",     32'(word_valid), 32'd0);
        chk("rst_idx",       32'(word_idx),   32'd0);
        chk("rst_tri_count", 32'(tri_count),  32'd0);
        chk("rst_word",      word_out,        32'd0);
        chk("rst_in_ready",  32'(in_ready),   32'd1);
        chk("rst_last",      32'(word_last),  32'd0);

        // Single triangle, hand-computed words
        ta = mk_tri(1, 2, 3, 4, 5, 6, 7, 8, 9);
        ca = mk_col('hAA, 'hBB, 'hCC);
        push_exp(32'h00020001, 0);
        push_exp(32'h00040003, 1);
        push_exp(32'h00060005, 2);
        push_exp(32'h00080007, 3);
        push_exp(32'hBBAA0009, 4);
        push_exp(32'h000000CC, 5);
        word_ready = 1'b1;
        send_tri(ta, ca, 1'b0);
        in_valid = 1'b0;
        drain(50);
        chk("single_tri_count", 32'(tri_count), 32'd1);
        chk("single_idle",      32'(word_valid), 32'd0);

        // Back-to-back triangles, no gap cycle
        do_reset();
        tb2 = mk_tri('h101, 'h102, 'h103, 'h104, 'h105, 'h106, 'h107, 'h108, 'h109);
        cb  = mk_col('h11, 'h22, 'h33);
        word_ready = 1'b1;
        got = 0;
        fork
            begin
                send_tri(ta, ca, 1'b1);
                send_tri(tb2, cb, 1'b1);
                in_valid = 1'b0;
            end
            begin
                int w;
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (word_valid !== 1'b1 && w < 20);
                for (int k = 0; k < 12; k++) begin
                    if (k > 0) @(negedge clk);
                    if (word_valid === 1'b1 && word_ready === 1'b1) got++;
                end
            end
        join
        chk("b2b_no_gap", 32'(got), 32'd12);
        drain(50);
        chk("b2b_tri_count", 32'(tri_count), 32'd2);

        // Backpressure at W2
        do_reset();
        tc = mk_tri('h10, 'h11, 'h12, 'h20, 'h21, 'h22, 'h30, 'h31, 'h32);
        cc = mk_col('h01, 'h02, 'h03);
        word_ready = 1'b1;
        send_tri(tc, cc, 1'b1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        word_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_idx",  32'(word_idx), 32'd2);
            chk("bp_word", word_out,      32'h00220021);
            @(posedge clk); #1;
        end
        chk("bp_idx_end",  32'(word_idx), 32'd2);
        word_ready = 1'b1;
        drain(50);
        chk("bp_tri_count", 32'(tri_count), 32'd1);

        // Reset after W3 is accepted
        do_reset();
        word_ready = 1'b1;
        base = hs_cnt;
        send_tri(ta, ca, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (hs_cnt >= base + 4) break;
            @(posedge clk);
        end
        #1;
        n_rst      = 1'b1;
        word_ready = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b0;
        exp_q.delete();
        chk("midrst_valid",     32'(word_valid), 32'd0);
        chk("midrst_tri_count", 32'(tri_count),  32'd0);
        chk("midrst_in_ready",  32'(in_ready),   32'd1);
        word_ready = 1'b1;
        send_tri(tb2, cb, 1'b1);
        in_valid = 1'b0;
        drain(50);
        chk("midrst_tri_count2", 32'(tri_count), 32'd1);

        // Counter wrap
        do_reset();
        force dut.tri_count = 16'hFFFF;
        @(posedge clk); #1;
        release dut.tri_count;
        chk("wrap_preload", 32'(tri_count), 32'h0000FFFF);
        word_ready = 1'b1;
        send_tri(tc, cc, 1'b1);
        in_valid = 1'b0;
        drain(50);
        chk("wrap_tri_count", 32'(tri_count), 32'd0);

        // Random valid/ready throttling
        do_reset();
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    Triangle3D t;
                    Color8     c;
                    t = mk_tri(int'($urandom()), int'($urandom()), int'($urandom()),
                               int'($urandom()), int'($urandom()), int'($urandom()),
                               int'($urandom()), int'($urandom()), int'($urandom()));
                    c = mk_col(int'($urandom()), int'($urandom()), int'($urandom()));
                    send_tri(t, c, 1'b1);
                    if ($urandom_range(0, 2) != 0) begin
                        in_valid = 1'b0;
                        repeat ($urandom_range(0, 2)) @(posedge clk);
                        #1;
                    end
                end
                in_valid = 1'b0;
                drain(500);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    word_ready = ($urandom_range(0, 3) != 0);
                end
                word_ready = 1'b1;
            end
        join
        chk("rnd_tri_count", 32'(tri_count), 32'd1000);
        chk("final_queue",   32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
